// File: rtl/stage_act_pkg.sv
// Shared types for the activation stage: sample format, activation modes, frame FSM states.
package stage_act_pkg;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_24_8;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10
  } act_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } frame_state_t;

  localparam logic [7:0] FLT_EXP_MAX = 8'hFF;
  localparam int unsigned ACT_FIFO_W = 33;

endpackage

// File: rtl/stage_act_fifo.sv
// Synchronous FIFO of DEPTH entries; head entry and occupancy come straight from registers.
module stage_act_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/stage_act.sv
// Activation stage: pass / ReLU / leaky ReLU on float_24_8 samples, frame tracking, output FIFO.
module stage_act
  import stage_act_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      data_in,
  input  logic             data_in_fst,
  input  logic             data_in_vld,
  output logic             data_in_rdy,
  input  logic [1:0]       mode,
  input  logic [3:0]       leak_shift,
  input  logic [LEN_W-1:0] frame_length,
  output logic [31:0]      data_out,
  output logic             data_out_fst,
  output logic             data_out_vld,
  input  logic             data_out_rdy,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  p1_load;
  logic                  p1_vld;
  logic                  p1_fst;
  float_24_8             p1_data;
  float_24_8             din_f;
  float_24_8             act_f;
  logic [ACT_FIFO_W-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;

  frame_state_t          state, state_n;
  logic [LEN_W-1:0]      cnt, cnt_n;
  logic [LEN_W-1:0]      len_eff;
  logic [LEN_W:0]        cnt_inc;
  logic                  done_n;
  logic                  err_n;

  assign accept       = data_in_vld && data_in_rdy;
  assign data_out_vld = (fifo_count != '0);
  assign pop          = data_out_vld && data_out_rdy;
  assign push         = p1_vld && ((fifo_count < CW'(DEPTH)) || pop);
  assign p1_load      = !p1_vld || push;
  assign data_out     = fifo_dout[31:0];
  assign data_out_fst = fifo_dout[32];

  assign din_f = data_in;

  always_comb begin
    act_f = din_f;
    if (din_f.sgn && (din_f.exp != FLT_EXP_MAX)) begin
      case (act_mode_t'(mode))
        ACT_RELU: act_f = '0;
        ACT_LEAKY: begin
          if (leak_shift != '0) begin
            if (din_f.exp > {4'b0000, leak_shift}) act_f.exp = din_f.exp - {4'b0000, leak_shift};
            else                                   act_f     = '0;
          end
        end
        default: act_f = din_f;
      endcase
    end
  end

  // P1 only advances when its current beat can enter the FIFO this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_vld  <= 1'b0;
      p1_fst  <= 1'b0;
      p1_data <= '0;
    end else if (p1_load) begin
      p1_vld <= accept;
      if (accept) begin
        p1_data <= act_f;
        p1_fst  <= data_in_fst;
      end
    end
  end

  // One-cycle-late ready is safe: P1 absorbs the single extra beat this allows.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(p1_vld);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_in_rdy <= 1'b0;
    else       data_in_rdy <= (occupancy < (CW+1)'(DEPTH));
  end

  stage_act_fifo #(
    .DEPTH (DEPTH),
    .W     (ACT_FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({p1_fst, p1_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign len_eff = (frame_length == '0) ? LEN_W'(1) : frame_length;
  assign cnt_inc = {1'b0, cnt} + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = frame_err;
    if (accept) begin
      if (data_in_fst) begin
        if (state == ST_RUN) err_n = 1'b1;
        if (len_eff == LEN_W'(1)) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          state_n = ST_RUN;
          cnt_n   = LEN_W'(1);
        end
      end else if (state == ST_IDLE) begin
        err_n = 1'b1;
      end else if (cnt_inc == {1'b0, len_eff}) begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_stage_act.sv
// Directed and randomized checks of stage_act against a field-level activation model and a frame model.
module tb_stage_act;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_fst = 1'b0;
  logic        data_in_vld = 1'b0;
  logic        data_in_rdy;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  leak_shift = 4'd0;
  logic [7:0]  frame_length = 8'd1;
  logic [31:0] data_out;
  logic        data_out_fst;
  logic        data_out_vld;
  logic        data_out_rdy = 1'b0;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  bit m_in_frame = 0;
  int m_cnt = 0;
  bit m_err = 0;
  bit m_done = 0;
  bit rand_sink = 0;
  bit sink_fixed = 0;

  stage_act #(
    .DEPTH (4),
    .LEN_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_fst  (data_in_fst),
    .data_in_vld  (data_in_vld),
    .data_in_rdy  (data_in_rdy),
    .mode         (mode),
    .leak_shift   (leak_shift),
    .frame_length (frame_length),
    .data_out     (data_out),
    .data_out_fst (data_out_fst),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1;
    data_out_rdy = rand_sink ? ($urandom_range(0, 99) < 60) : sink_fixed;
  end

  function automatic logic [31:0] ref_act(input logic [31:0] v, input logic [1:0] md,
                                          input logic [3:0] sh);
    int e;
    e = int'(v[30:23]);
    if (e == 255 || !v[31]) return v;
    case (md)
      2'd1: return 32'h0;
      2'd2: begin
        if (sh == 4'd0) return v;
        if (e <= int'(sh)) return 32'h0;
        return {1'b1, 8'(e - int'(sh)), v[22:0]};
      end
      default: return v;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && data_out_vld && data_out_rdy) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL out_unexpected: got %h fst %b expected no beat", data_out, data_out_fst);
      end
      if (exp_q.size() != 0) begin
        checks++;
        assert ({data_out_fst, data_out} === exp_q[0])
        else begin
          errors++;
          $error("FAIL out_beat: got %h expected %h", {data_out_fst, data_out}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at accept edge + 1: records the expected output and checks frame flags.
  task automatic model_accept(input logic [31:0] d, input logic f);
    int len;
    len = (frame_length == 8'd0) ? 1 : int'(frame_length);
    exp_q.push_back({f, ref_act(d, mode, leak_shift)});
    m_done = 0;
    if (f) begin
      if (m_in_frame) m_err = 1;
      if (len <= 1) begin
        m_done = 1; m_in_frame = 0; m_cnt = 0;
      end else begin
        m_in_frame = 1; m_cnt = 1;
      end
    end else if (!m_in_frame) begin
      m_err = 1;
    end else begin
      m_cnt++;
      if (m_cnt == len) begin
        m_done = 1; m_in_frame = 0; m_cnt = 0;
      end
    end
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic send(input logic [31:0] d, input logic f);
    bit acc;
    acc = 0;
    data_in = d;
    data_in_fst = f;
    data_in_vld = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = data_in_rdy;
      @(posedge clk);
      #1;
    end
    data_in_vld = 1'b0;
    checks++;
    assert (acc)
    else begin
      errors++;
      $error("FAIL send_timeout: got no accept expected accept of %h", d);
    end
    if (acc) model_accept(d, f);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    m_in_frame = 0; m_cnt = 0; m_err = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_sample();
    int e;
    case ($urandom_range(0, 4))
      0:       e = 0;
      1:       e = 1;
      2:       e = $urandom_range(0, 16);
      3:       e = 255;
      default: e = $urandom_range(0, 255);
    endcase
    return {1'($urandom), 8'(e), 23'($urandom)};
  endfunction

  initial begin
    int n;
    bit acc;
    int len;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", 32'(data_in_rdy), 32'd0);
    check("rst_out_vld", 32'(data_out_vld), 32'd0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_out_fst", 32'(data_out_fst), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rdy", 32'(data_in_rdy), 32'd1);

    // ReLU with latency check
    mode = 2'd1; frame_length = 8'd3; sink_fixed = 1;
    repeat (2) @(posedge clk);
    #1;
    send(32'h3F800000, 1'b1);
    check("lat_edge1_vld", 32'(data_out_vld), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2_vld", 32'(data_out_vld), 32'd1);
    check("lat_edge2_data", data_out, 32'h3F800000);
    send(32'hBF800000, 1'b0);
    send(32'h80000000, 1'b0);
    drain();

    // Leaky ReLU, shift 2 and shift 0
    mode = 2'd2; leak_shift = 4'd2; frame_length = 8'd1;
    send(32'hC0000000, 1'b1);
    send({1'b1, 8'd1, 23'h123456}, 1'b1);
    send({1'b1, 8'd2, 23'h000001}, 1'b1);
    send({1'b1, 8'd3, 23'h7FFFFF}, 1'b1);
    send(32'hFF800000, 1'b1);
    leak_shift = 4'd0;
    send(32'hC0400000, 1'b1);
    drain();

    // Backpressure: sink stalled, count accepted beats
    mode = 2'd0; frame_length = 8'd5; sink_fixed = 0;
    repeat (2) @(posedge clk);
    #1;
    n = 0;
    data_in = 32'h00000100; data_in_fst = 1'b1; data_in_vld = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = data_in_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        model_accept(data_in, data_in_fst);
        n++;
        data_in = data_in + 32'd1;
        data_in_fst = 1'b0;
      end
    end
    data_in_vld = 1'b0;
    check("bp_accepted", 32'(n), 32'd5);
    check("bp_in_rdy", 32'(data_in_rdy), 32'd0);
    check("bp_out_vld", 32'(data_out_vld), 32'd1);
    sink_fixed = 1;
    drain();

    // Frame of 3 twice, mixed modes
    frame_length = 8'd3; mode = 2'd1;
    send(32'h41200000, 1'b1);
    send(32'hC1200000, 1'b0);
    send(32'h40000000, 1'b0);
    mode = 2'd3;
    send(32'hC1200000, 1'b1);
    send(32'h00000000, 1'b0);
    send(32'h7FC00000, 1'b0);
    drain();

    // Framing errors: fst mid-frame, then beat without fst in IDLE
    frame_length = 8'd4; mode = 2'd0;
    send(32'h1, 1'b1);
    send(32'h2, 1'b0);
    send(32'h3, 1'b1);
    send(32'h4, 1'b0);
    send(32'h5, 1'b0);
    send(32'h6, 1'b0);
    drain();
    do_reset();
    check("err_cleared", 32'(frame_err), 32'd0);
    send(32'h7, 1'b0);
    drain();

    // Reset with three beats held in the FIFO
    do_reset();
    sink_fixed = 0; frame_length = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    send(32'hA, 1'b1);
    send(32'hB, 1'b0);
    send(32'hC, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_vld", 32'(data_out_vld), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    m_in_frame = 0; m_cnt = 0; m_err = 0; m_done = 0;
    #1;
    check("rst_now_vld", 32'(data_out_vld), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sink_fixed = 1;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_vld", 32'(data_out_vld), 32'd0);

    // Randomized frames with random sink stalls
    rand_sink = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      frame_length = ((len == 1) && ($urandom_range(0, 1) == 1)) ? 8'd0 : 8'(len);
      mode = 2'($urandom_range(0, 3));
      leak_shift = 4'($urandom_range(0, 15));
      for (int b = 0; b < len; b++) send(rand_sample(), (b == 0));
    end
    rand_sink = 0;
    sink_fixed = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
